// File: rtl/serial_tx_framer_if.sv
// Word handshake between the lab control logic and the serial framer.
// The control side drives data/valid (master); the framer returns ready (slave).
interface serial_tx_framer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/serial_tx_framer.sv
// Start/stop framed serial transmitter, LSB first, CLKS_PER_BIT clocks per bit.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit between data and stop.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | line high, ready for a word
// S_START  | start bit (line low)
// S_DATA   | payload bits, shreg_q[0] on the line, shifted at each bit end
// S_PARITY | even parity of the latched word (parity build only)
// S_STOP   | stop bit (line high); last cycle pulses done and may accept
module serial_tx_framer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                rst,
  serial_tx_framer_if.slave   tx_if,
  output logic                tx_serial,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                serial_q, serial_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic                bit_end;
  logic                accept;
  logic                load;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    load    = 1'b0;
    bit_end = (baud_q == BAUD_LAST);
    accept  = tx_if.tx_valid && ready_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        load   = accept;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Ready is already high on the final stop cycle, so a waiting word
        // is taken here and its start bit follows with no idle gap.
        if (bit_end) begin
          if (accept) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    if (load) begin
      state_d = S_START;
      baud_d  = '0;
      bit_d   = '0;
      shreg_d = tx_if.tx_data;
`ifdef SERIAL_TX_PARITY_EN
      parity_d = ^tx_if.tx_data;
`endif
    end

    // Outputs are registered, so they are decoded from the next state.
    done_d  = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    ready_d = (state_d == S_IDLE) || done_d;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: serial_d = parity_d;
`endif
      default:  serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_if.tx_ready = ready_q;
  assign tx_serial      = serial_q;
  assign tx_busy        = busy_q;
  assign tx_done        = done_q;

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: frame-level reference model checked every cycle,
// directed frames pinned to hand-computed line patterns, then random traffic.
module tb_serial_tx_framer;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = DW + 3;
  localparam logic [NB-1:0] LINE_A5 = 11'b10101001010;
  localparam logic [NB-1:0] LINE_81 = 11'b10100000010;
  localparam logic [NB-1:0] LINE_07 = 11'b11000001110;
`else
  localparam int NB = DW + 2;
  localparam logic [NB-1:0] LINE_A5 = 10'b1101001010;
  localparam logic [NB-1:0] LINE_81 = 10'b1100000010;
  localparam logic [NB-1:0] LINE_07 = 10'b1000001110;
`endif
  localparam int L = NB * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx_serial, tx_busy, tx_done;

  int total = 0;
  int bad   = 0;

  serial_tx_framer_if #(.DATA_W(DW)) tx_if ();
  assign tx_if.tx_data  = tx_data;
  assign tx_if.tx_valid = tx_valid;
  assign tx_ready       = tx_if.tx_ready;

  serial_tx_framer #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_if     (tx_if),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t want < 500000", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k counts cycles since the accepting edge (1..L);
  // the line value at cycle k follows from which bit period k falls in.
  bit            chk_on   = 1'b0;
  bit            m_armed  = 1'b0;
  bit            m_active = 1'b0;
  int            m_k      = 0;
  logic [DW-1:0] m_word   = '0;

  function automatic logic line_at(input logic [DW-1:0] w, input int k);
    int b;
    b = (k - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
`ifdef SERIAL_TX_PARITY_EN
    if (b == DW + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  logic exp_ready, exp_busy, exp_done, exp_serial;
  assign exp_ready  = m_armed && (!m_active || m_k == L);
  assign exp_busy   = m_active;
  assign exp_done   = m_active && (m_k == L);
  assign exp_serial = m_active ? line_at(m_word, m_k) : 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      chk_on   <= 1'b1;
      m_armed  <= 1'b0;
      m_active <= 1'b0;
      m_k      <= 0;
    end else begin
      m_armed <= 1'b1;
      if (exp_ready && tx_valid) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_word   <= tx_data;
      end else if (m_active) begin
        if (m_k == L) begin
          m_active <= 1'b0;
          m_k      <= 0;
        end else begin
          m_k <= m_k + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_serial", tx_serial, exp_serial);
      chk("model_ready",  tx_ready,  exp_ready);
      chk("model_busy",   tx_busy,   exp_busy);
      chk("model_done",   tx_done,   exp_done);
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", tx_ready, 1'b1);
  endtask

  // Sends one word with a one-cycle valid, then samples each bit mid-period.
  task automatic frame_capture(input logic [DW-1:0] d, input logic [DW-1:0] d_mid,
                               input bit poke_valid, output logic [15:0] bits,
                               output int done_at, output int busy_cnt);
    wait_ready();
    tx_data  = d;
    tx_valid = 1'b1;
    bits     = '1;
    done_at  = 0;
    busy_cnt = 0;
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        tx_valid = 1'b0;
        tx_data  = d_mid;
      end
      if (tx_busy === 1'b1) busy_cnt++;
      if (tx_done === 1'b1 && done_at == 0) done_at = k;
      if ((k - 1) % CPB == 1) bits[(k-1)/CPB] = tx_serial;
      if (poke_valid && k == 12) begin
        tx_valid = 1'b1;
        chk("ready_midframe", tx_ready, 1'b0);
      end
      if (poke_valid && k == 14) tx_valid = 1'b0;
    end
  endtask

  function automatic logic b2b_exp(input int k);
    if (k <= L - CPB) return 1'b0;
    if (k <= L) return 1'b1;
    if (k <= L + CPB) return 1'b0;
    if (k <= L + (DW + 1) * CPB) return 1'b1;
    if (k <= 2 * L - CPB) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic [15:0] bits;
    int          done_at;
    int          busy_cnt;
    int          gap;
    int          hold;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", tx_ready, 1'b0);
    chk("reset_serial", tx_serial, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", tx_ready, 1'b1);

    // 0xA5, tx_data cleared and a stray valid pulse mid-frame
    frame_capture(8'hA5, 8'h00, 1'b1, bits, done_at, busy_cnt);
    chk("a5_line", 32'(bits[NB-1:0]), 32'(LINE_A5));
    chk("a5_done_cycle", done_at, L);
    chk("a5_busy_cycles", busy_cnt, L);

    frame_capture(8'h07, 8'hFF, 1'b0, bits, done_at, busy_cnt);
    chk("x07_line", 32'(bits[NB-1:0]), 32'(LINE_07));
    chk("x07_done_cycle", done_at, L);

    // back-to-back 0x00 then 0xFF with valid held high
    wait_ready();
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    for (int k = 1; k <= 2 * L; k++) begin
      @(negedge clk);
      if (k == 1) tx_data = 8'hFF;
      if (k == L + 1) tx_valid = 1'b0;
      chk("b2b_line", tx_serial, b2b_exp(k));
      if (k == L) begin
        chk("b2b_done", tx_done, 1'b1);
        chk("b2b_ready", tx_ready, 1'b1);
      end
      if (k == L + 1) chk("b2b_busy_gapless", tx_busy, 1'b1);
    end

    // reset during data bit 3 of 0x3C
    wait_ready();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    for (int k = 1; k <= 4 * CPB + 2; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_serial", tx_serial, 1'b1);
    chk("abort_done", tx_done, 1'b0);
    chk("abort_busy", tx_busy, 1'b0);
    @(negedge clk);
    chk("abort_ready", tx_ready, 1'b1);
    frame_capture(8'h81, 8'h81, 1'b0, bits, done_at, busy_cnt);
    chk("x81_line", 32'(bits[NB-1:0]), 32'(LINE_81));
    chk("x81_done_cycle", done_at, L);

    // random traffic: gaps, long valid holds, data churn, occasional reset
    for (int it = 0; it < 40; it++) begin
      gap  = int'($urandom_range(0, 4));
      hold = int'($urandom_range(1, L + 6));
      repeat (gap) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = DW'($urandom);
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        tx_data = DW'($urandom);
      end
      tx_valid = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        repeat (int'($urandom_range(0, L))) @(negedge clk);
        rst = 1'b1;
        repeat (int'($urandom_range(1, 2))) @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (L + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_tx_framer.md
Name: serial_tx_framer

Overview:
- Parallel-to-serial framed transmitter; the sending end of the lab's single-wire serial link.
- Accepts one DATA_W-bit word per valid/ready handshake and shifts it out LSB-first inside a start/stop frame.
- Each bit is held for CLKS_PER_BIT clocks.
- Sits between lab control logic (switches/FSMs) and a board pin or the matching serial receiver.

Parameters:
- DATA_W, 8, payload bits per frame (1..16)
- CLKS_PER_BIT, 868, clocks per serial bit (100 MHz / 115200 baud); must be >= 2

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tx_data  input  DATA_W  word to send; sampled only on an accepted handshake
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  block can accept a word this cycle
- tx_serial  output  1  serial line, idles high
- tx_busy  output  1  a frame is in progress
- tx_done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- One clock domain. Reset is synchronous and active-high: rst sampled high on a rising clk edge resets the block. All outputs are registered.
- Reset values: tx_serial=1, tx_ready=0, tx_busy=0, tx_done=0, FSM=IDLE, bit counter=0, baud counter=0.
- tx_ready rises the first cycle after rst deasserts.
- FSM states and transitions:
  - IDLE: tx_ready=1, tx_serial=1, tx_busy=0. Handshake = tx_valid && tx_ready on a clock edge. That edge latches tx_data into the shift register, clears both counters and goes to START. tx_ready=0 from the next cycle.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_serial = shreg[0] for CLKS_PER_BIT cycles per bit. Shift right at the end of each bit. After DATA_W bits, go to STOP (or to PARITY, see Optional Feature).
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles. On the final cycle, pulse tx_done=1 for exactly one cycle, assert tx_ready=1 and go to IDLE.
- Frame latency: first start-bit cycle is the cycle after the handshake. Frame length is exactly (DATA_W+2)*CLKS_PER_BIT cycles, or one more bit period with parity enabled.
- tx_busy=1 from the cycle after the handshake through the last stop cycle.
- Back-to-back: tx_valid held high is accepted on the tx_done cycle. The next start bit follows immediately, so there is no extra idle bit.
- tx_data and tx_valid are ignored while busy. Changes to tx_data mid-frame must not affect the line.
- Baud counter width is $clog2(CLKS_PER_BIT). It wraps from CLKS_PER_BIT-1 to 0 with no dropped or extra cycles. Bit counter width is $clog2(DATA_W+1).
- Reset mid-frame: the frame aborts on that edge. tx_serial=1 from the next cycle, and no tx_done is produced.
- tx_valid asserted during rst is not accepted.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the latched payload, computed at the handshake) for CLKS_PER_BIT cycles. Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
1. Reset check: rst high for 3 cycles, then low → tx_serial=1, tx_busy=0 and tx_done=0 throughout; tx_ready=0 during reset and 1 on the first cycle after.
2. Single frame, DATA_W=8, CLKS_PER_BIT=4, tx_data=0xA5 pulsed with tx_valid for 1 cycle:
   - Line per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1.
   - tx_done pulses at cycle 40 after the handshake; tx_busy=1 for cycles 1..40.
3. Back-to-back: tx_valid held high with 0x00 then 0xFF.
   - Second handshake occurs on the tx_done cycle of the first frame.
   - Line shows 0 for 36 cycles, 1 for 4 (stop), 0 for 4 (start), 1 for 36.
   - No idle gap between frames.
4. Mid-frame reset: send 0x3C, assert rst for 1 cycle during data bit 3 → tx_serial=1 next cycle, no tx_done, tx_ready=1 afterward. A new 0x81 then transmits correctly.
5. Data stability: change tx_data to 0x00 after the 0xA5 handshake with tx_valid low → serialized bits still match 0xA5. tx_valid=1 mid-frame is not accepted (tx_ready=0).
6. With SERIAL_TX_PARITY_EN, CLKS_PER_BIT=4: 0xA5 gives parity bit 0; 0x07 gives parity bit 1. Frame is 44 cycles, and tx_done comes at cycle 44.
